// File: rtl/alu_serial_pkg.sv
// Shared definitions for the slice-serial ALU: op codes, flag layout, FSM state encodings
// and small op-classification helpers.
package alu_serial_pkg;

  localparam logic [2:0] ADD_OP = 3'd0;
  localparam logic [2:0] ADC_OP = 3'd1;
  localparam logic [2:0] SUB_OP = 3'd2;
  localparam logic [2:0] SBC_OP = 3'd3;
  localparam logic [2:0] AND_OP = 3'd4;
  localparam logic [2:0] XOR_OP = 3'd5;
  localparam logic [2:0] OR_OP  = 3'd6;
  localparam logic [2:0] CP_OP  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Packs to {Z,N,H,C}, matching the out_flags bit order.
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == SUB_OP) || (op == SBC_OP) || (op == CP_OP);
  endfunction

  function automatic logic op_is_logic(input logic [2:0] op);
    return (op == AND_OP) || (op == XOR_OP) || (op == OR_OP);
  endfunction

  function automatic logic op_uses_cin(input logic [2:0] op);
    return (op == ADC_OP) || (op == SBC_OP);
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// One SLICE_W-bit slice of the serial ALU: purely combinational, carry/borrow in and out.
// Add-class ops always consume in_C; the top zeroes it on slice 0 when the op has no carry-in.
module alu_slice
  import alu_serial_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] in_A,
  input  logic [SLICE_W-1:0] in_B,
  input  logic [2:0]         alu_op,
  input  logic               in_C,
  output logic [SLICE_W-1:0] out,
  output logic               out_Z,
  output logic               out_C
);

  logic [SLICE_W:0] sum_w;
  logic [SLICE_W:0] diff_w;

  assign sum_w  = {1'b0, in_A} + {1'b0, in_B} + {{SLICE_W{1'b0}}, in_C};
  // Bit SLICE_W of the difference is the borrow out (set when A < B + cin).
  assign diff_w = {1'b0, in_A} - {1'b0, in_B} - {{SLICE_W{1'b0}}, in_C};

  always_comb begin
    out   = '0;
    out_C = 1'b0;
    case (alu_op)
      ADD_OP, ADC_OP: begin
        out   = sum_w[SLICE_W-1:0];
        out_C = sum_w[SLICE_W];
      end
      SUB_OP, SBC_OP, CP_OP: begin
        out   = diff_w[SLICE_W-1:0];
        out_C = diff_w[SLICE_W];
      end
      AND_OP:  out = in_A & in_B;
      XOR_OP:  out = in_A ^ in_B;
      OR_OP:   out = in_A | in_B;
      default: out = '0;
    endcase
  end

  assign out_Z = ~|out;

endmodule

// File: rtl/alu_serial.sv
// Slice-serial ALU: DATA_W operands processed SLICE_W bits per clock, LSB slice first, with a
// start/done handshake and {Z,N,H,C} flags. Define ALU_SERIAL_HFLAG_EN for a bit-3 half-carry.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  input  logic [2:0]        alu_op,
  input  logic              in_C,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic [3:0]        out_flags
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [2:0]        op_q, op_d;
  logic              carry_q, carry_d;
  logic              zacc_q, zacc_d;
  alu_flags_t        flags_q, flags_d;

  logic [SLICE_W-1:0] a_slice [NUM_SLICES];
  logic [SLICE_W-1:0] b_slice [NUM_SLICES];
  logic [SLICE_W-1:0] cur_a, cur_b, slice_res;
  logic               slice_z, slice_c, h_flag, last_slice;

  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_split
    assign a_slice[gi] = a_q[gi*SLICE_W +: SLICE_W];
    assign b_slice[gi] = b_q[gi*SLICE_W +: SLICE_W];
  end

  always_comb begin : slice_mux
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        cur_a = a_slice[i];
        cur_b = b_slice[i];
      end
    end
  end

  alu_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .in_A  (cur_a),
    .in_B  (cur_b),
    .alu_op(op_q),
    .in_C  (carry_q),
    .out   (slice_res),
    .out_Z (slice_z),
    .out_C (slice_c)
  );

  assign last_slice = (cnt_q == LAST_SLICE);

  // Each RUN cycle deposits the current slice result into its own field of res.
  always_comb begin : res_insert
    res_d = res_q;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_SLICES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          res_d[i*SLICE_W +: SLICE_W] = slice_res;
        end
      end
    end
  end

`ifdef ALU_SERIAL_HFLAG_EN
  localparam logic [CNT_W-1:0] H_SLICE = CNT_W'(4 / SLICE_W - 1);

  logic half_q, half_d;

  // Carry/borrow leaving the slice that ends at bit 3 is the half-carry.
  assign half_d = (state_q == ST_RUN && cnt_q == H_SLICE) ? slice_c : half_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      half_q <= 1'b0;
    end else begin
      half_q <= half_d;
    end
  end

  assign h_flag = op_is_logic(op_q) ? (op_q == AND_OP) : half_d;
`else
  assign h_flag = (op_q == AND_OP);
`endif

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = in_A;
          b_d     = in_B;
          op_d    = alu_op;
          carry_d = op_uses_cin(alu_op) & in_C;
          zacc_d  = 1'b1;
        end
      end
      ST_RUN: begin
        carry_d = slice_c;
        zacc_d  = zacc_q & slice_z;
        if (last_slice) begin
          state_d   = ST_DONE;
          cnt_d     = '0;
          // cp reports flags only; the visible result stays the captured A.
          out_d     = (op_q == CP_OP) ? a_q : res_d;
          flags_d.z = zacc_q & slice_z;
          flags_d.n = op_is_sub(op_q);
          flags_d.h = h_flag;
          flags_d.c = op_is_logic(op_q) ? 1'b0 : slice_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      op_q    <= ADD_OP;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      flags_q <= flags_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign out       = out_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: table vectors and random ops on an 8/4 instance through a scoreboard,
// plus hand sequences for ignored starts, mid-run reset, and 16/4 and 4/4 instances.
`timescale 1ns/1ps
module tb_alu_serial;
  import alu_serial_pkg::*;

`ifdef ALU_SERIAL_HFLAG_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic clock;
  logic reset_n;

  logic        s8_start, s8_cin, s8_busy, s8_done;
  logic [7:0]  s8_a, s8_b, s8_out;
  logic [2:0]  s8_op;
  logic [3:0]  s8_flags;

  logic        w16_start, w16_cin, w16_busy, w16_done;
  logic [15:0] w16_a, w16_b, w16_out;
  logic [2:0]  w16_op;
  logic [3:0]  w16_flags;

  logic        w4_start, w4_cin, w4_busy, w4_done;
  logic [3:0]  w4_a, w4_b, w4_out;
  logic [2:0]  w4_op;
  logic [3:0]  w4_flags;

  alu_serial #(.DATA_W(8), .SLICE_W(4)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(s8_start), .in_A(s8_a), .in_B(s8_b),
    .alu_op(s8_op), .in_C(s8_cin), .busy(s8_busy), .done(s8_done), .out(s8_out),
    .out_flags(s8_flags));

  alu_serial #(.DATA_W(16), .SLICE_W(4)) dut16 (
    .clock(clock), .reset_n(reset_n), .start(w16_start), .in_A(w16_a), .in_B(w16_b),
    .alu_op(w16_op), .in_C(w16_cin), .busy(w16_busy), .done(w16_done), .out(w16_out),
    .out_flags(w16_flags));

  alu_serial #(.DATA_W(4), .SLICE_W(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(w4_start), .in_A(w4_a), .in_B(w4_b),
    .alu_op(w4_op), .in_C(w4_cin), .busy(w4_busy), .done(w4_done), .out(w4_out),
    .out_flags(w4_flags));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // Full-width reference: returns {Z,N,H,C, out[31:0]}.
  function automatic logic [35:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [31:0] mask, r, o;
    logic [32:0] wide;
    logic        ci, z, n, h, c;
    mask = (32'd1 << w) - 32'd1;
    ci   = (op == ADC_OP || op == SBC_OP) ? cin : 1'b0;
    r = '0; h = 1'b0; c = 1'b0; n = 1'b0;
    case (op)
      ADD_OP, ADC_OP: begin
        wide = {1'b0, a} + {1'b0, b} + 33'(ci);
        r    = wide[31:0] & mask;
        c    = (wide > {1'b0, mask});
        h    = ({28'b0, a[3:0]} + {28'b0, b[3:0]} + 32'(ci)) > 32'd15;
      end
      SUB_OP, SBC_OP, CP_OP: begin
        r = (a - b - 32'(ci)) & mask;
        c = (a < b + 32'(ci));
        h = ({28'b0, a[3:0]} < {28'b0, b[3:0]} + 32'(ci));
        n = 1'b1;
      end
      AND_OP:  r = a & b;
      XOR_OP:  r = a ^ b;
      default: r = a | b;
    endcase
    if (op == AND_OP || op == XOR_OP || op == OR_OP) h = (op == AND_OP);
    else if (!HEN) h = 1'b0;
    z = (r == 32'd0);
    o = (op == CP_OP) ? a : r;
    return {z, n, h, c, o};
  endfunction

  typedef struct {
    logic [7:0] exp_out;
    logic [3:0] exp_flags;
    int         acc_edge;
    int         tag;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  // Scoreboard consumer for the 8-bit instance.
  always @(negedge clock) begin
    if (reset_n && s8_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: out=0x%0h flags=%b, required no done pulse", s8_out, s8_flags);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("v%0d_out", mon_e.tag), 32'(s8_out), 32'(mon_e.exp_out));
        check($sformatf("v%0d_flags", mon_e.tag), 32'(s8_flags), 32'(mon_e.exp_flags));
        check($sformatf("v%0d_latency", mon_e.tag), 32'(edge_cnt - mon_e.acc_edge), 32'd2);
      end
    end
  end

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] eo, input logic [3:0] ef, input int tag);
    int guard;
    guard = 0;
    while ((s8_busy || s8_done) && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 60) begin
      n_checks++;
      $display("FAIL v%0d_idle_wait: busy=%b done=%b, required idle within 60 cycles", tag, s8_busy, s8_done);
    end
    s8_op = op; s8_a = a; s8_b = b; s8_cin = cin; s8_start = 1'b1;
    @(posedge clock);
    #1;
    sb_q.push_back('{exp_out: eo, exp_flags: ef, acc_edge: edge_cnt, tag: tag});
    @(negedge clock);
    s8_start = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] eo, input logic [3:0] ef, input string nm);
    int acc, guard;
    @(negedge clock);
    w16_op = op; w16_a = a; w16_b = b; w16_cin = cin; w16_start = 1'b1;
    @(posedge clock);
    #1 acc = edge_cnt;
    @(negedge clock);
    w16_start = 1'b0;
    guard = 0;
    while (!w16_done && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    check({nm, "_done"}, 32'(w16_done), 32'd1);
    check({nm, "_out"}, 32'(w16_out), 32'(eo));
    check({nm, "_flags"}, 32'(w16_flags), 32'(ef));
    check({nm, "_latency"}, 32'(edge_cnt - acc), 32'd4);
  endtask

  task automatic issue4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic [3:0] eo, input logic [3:0] ef, input string nm);
    int acc, guard;
    @(negedge clock);
    w4_op = op; w4_a = a; w4_b = b; w4_cin = cin; w4_start = 1'b1;
    @(posedge clock);
    #1 acc = edge_cnt;
    guard = 0;
    while (!w4_done && guard < 40) begin
      @(negedge clock);
      w4_start = 1'b0;
      guard++;
    end
    w4_start = 1'b0;
    check({nm, "_done"}, 32'(w4_done), 32'd1);
    check({nm, "_out"}, 32'(w4_out), 32'(eo));
    check({nm, "_flags"}, 32'(w4_flags), 32'(ef));
    check({nm, "_latency"}, 32'(edge_cnt - acc), 32'd1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_out;
    logic [3:0] exp_flags;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vt [NVEC];

  initial begin
    logic [2:0]  r_op;
    logic [7:0]  r_a, r_b;
    logic        r_c;
    logic [35:0] m;
    int          guard;

    // Flags are {Z,N,H,C}.
    vt[0]  = '{ADD_OP, 8'h3A, 8'hC6, 1'b1, 8'h00, {1'b1, 1'b0, HEN, 1'b1}};
    vt[1]  = '{ADC_OP, 8'h0F, 8'h00, 1'b1, 8'h10, {1'b0, 1'b0, HEN, 1'b0}};
    vt[2]  = '{SBC_OP, 8'h10, 8'h01, 1'b1, 8'h0E, {1'b0, 1'b1, HEN, 1'b0}};
    vt[3]  = '{SUB_OP, 8'h00, 8'h01, 1'b0, 8'hFF, {1'b0, 1'b1, HEN, 1'b1}};
    vt[4]  = '{CP_OP,  8'h42, 8'h42, 1'b0, 8'h42, 4'b1100};
    vt[5]  = '{CP_OP,  8'h10, 8'h20, 1'b0, 8'h10, 4'b0101};
    vt[6]  = '{AND_OP, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b1010};
    vt[7]  = '{XOR_OP, 8'h5A, 8'h5A, 1'b1, 8'h00, 4'b1000};
    vt[8]  = '{OR_OP,  8'h50, 8'h0A, 1'b0, 8'h5A, 4'b0000};
    vt[9]  = '{ADC_OP, 8'hFF, 8'h00, 1'b1, 8'h00, {1'b1, 1'b0, HEN, 1'b1}};
    vt[10] = '{SBC_OP, 8'h00, 8'h00, 1'b1, 8'hFF, {1'b0, 1'b1, HEN, 1'b1}};
    vt[11] = '{ADD_OP, 8'h12, 8'h34, 1'b1, 8'h46, 4'b0000};

    reset_n = 1'b0;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_op = '0; s8_cin = 1'b0;
    w16_start = 1'b0; w16_a = '0; w16_b = '0; w16_op = '0; w16_cin = 1'b0;
    w4_start = 1'b0; w4_a = '0; w4_b = '0; w4_op = '0; w4_cin = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(s8_busy), 32'd0);
    check("rst_done", 32'(s8_done), 32'd0);
    check("rst_out", 32'(s8_out), 32'd0);
    check("rst_flags", 32'(s8_flags), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < NVEC; i++) begin
      issue8(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, vt[i].exp_out, vt[i].exp_flags, i);
    end

    for (int i = 0; i < 8; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      r_c  = 1'($urandom);
      m    = model(8, r_op, {24'b0, r_a}, {24'b0, r_b}, r_c);
      issue8(r_op, r_a, r_b, r_c, m[7:0], m[35:32], 50 + i);
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 60) begin
      @(negedge clock);
      guard++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    // Starts during RUN and during DONE must not disturb the op in flight.
    issue8(SUB_OP, 8'h01, 8'h02, 1'b0, 8'hFF, {1'b0, 1'b1, HEN, 1'b1}, 100);
    s8_op = AND_OP; s8_a = 8'h0F; s8_b = 8'h0F; s8_start = 1'b1;
    @(negedge clock);
    s8_start = 1'b0;
    guard = 0;
    while (!s8_done && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("ign_run_done_seen", 32'(s8_done), 32'd1);
    s8_op = XOR_OP; s8_a = 8'h77; s8_b = 8'h00; s8_start = 1'b1;
    @(negedge clock);
    s8_start = 1'b0;
    repeat (3) @(negedge clock);
    check("ign_done_busy", 32'(s8_busy), 32'd0);
    check("hold_out", 32'(s8_out), 32'hFF);
    check("hold_flags", 32'(s8_flags), 32'({1'b0, 1'b1, HEN, 1'b1}));

    // Reset in the middle of RUN abandons the op with no done pulse.
    issue8(XOR_OP, 8'h0F, 8'hF3, 1'b0, 8'hFC, 4'b0000, 101);
    #2 reset_n = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_busy", 32'(s8_busy), 32'd0);
    check("midrst_done", 32'(s8_done), 32'd0);
    check("midrst_out", 32'(s8_out), 32'd0);
    check("midrst_flags", 32'(s8_flags), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("post_rst_busy", 32'(s8_busy), 32'd0);
    check("post_rst_out", 32'(s8_out), 32'd0);

    issue16(ADD_OP, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, {1'b1, 1'b0, HEN, 1'b1}, "w16_add");
    m = model(16, SBC_OP, 32'h1234, 32'h0235, 1'b1);
    issue16(SBC_OP, 16'h1234, 16'h0235, 1'b1, m[15:0], m[35:32], "w16_sbc");
    m = model(16, CP_OP, 32'h8000, 32'h8001, 1'b0);
    issue16(CP_OP, 16'h8000, 16'h8001, 1'b0, m[15:0], m[35:32], "w16_cp");

    issue4(SUB_OP, 4'h3, 4'h5, 1'b0, 4'hE, {1'b0, 1'b1, HEN, 1'b1}, "w4_sub");
    issue4(ADD_OP, 4'h9, 4'h7, 1'b0, 4'h0, {1'b1, 1'b0, HEN, 1'b1}, "w4_add");
    issue4(OR_OP, 4'h9, 4'h2, 1'b1, 4'hB, 4'b0000, "w4_or");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
